sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
Serial-in parallel-out frame receiver that consumes the single-bit stream produced by the serial shift stage. It hunts for a fixed sync pattern, assembles the following WIDTH data bits MSB-first, checks one even-parity bit, and presents good words through a 2-entry output buffer with a valid/ready handshake. Bits advance only on a one-cycle bit strobe, so the block runs from the same divided bit rate as the serial stage while clocked on the board clock.

Parameters:
WIDTH, 8, data bits per frame (2..16)
SYNC_LEN, 4, sync pattern length in bits (2..8)
SYNC, 4'b1011, sync pattern, first-received bit in MSB

Ports:
clk  input  1  system clock, all logic on rising edge
clear  input  1  synchronous active-high reset, priority over all inputs
si  input  1  serial data in (from the serial shift stage output)
bit_en  input  1  bit strobe; si sampled only on cycles with bit_en=1
dout  output  WIDTH  head word of output buffer, MSB = first data bit received
dout_valid  output  1  buffer non-empty
dout_ready  input  1  consumer accepts head when dout_valid=1
locked  output  1  high in DATA and PAR states
par_err  output  1  one-cycle pulse on parity failure
overflow  output  1  sticky: good frame dropped because buffer full
frame_cnt  output  8  count of frames pushed into buffer, wraps 255->0

Behaviour:
- Reset (clear=1 at clock edge): state=HUNT, window=0, fill count=0, bit count=0, buffer empty, dout=0, dout_valid=0, locked=0, par_err=0, overflow=0, frame_cnt=0. Applies mid-frame; partial frame discarded, bit_en/si ignored that cycle.
- All state advances only on bit_en=1 cycles; bit_en may be high every cycle or with arbitrary gaps; results are identical.
- HUNT: each strobe shifts si into SYNC_LEN-bit window (LSB in); fill count saturates at SYNC_LEN. Match = fill count==SYNC_LEN (including this bit) and window (including this bit)==SYNC -> DATA, bit count=0. Window and fill count cleared on every entry to HUNT; bits of a prior frame never contribute to a match. Overlapping search: non-matching bits slide, no restart.
- DATA: each strobe shifts si into data register (LSB in, earlier bits move toward MSB), bit count++; on WIDTH-th bit -> PAR.
- PAR: on strobe, parity = XOR(data bits, si). Parity==0: good frame. Parity==1: par_err=1 for the following cycle only, frame discarded, frame_cnt unchanged. Either case -> HUNT.
- Good frame push, visible the cycle after the parity strobe: if buffer count<2, or count==2 with a pop in the same cycle, push; frame_cnt++. Otherwise drop word, overflow<=1 (held until clear), frame_cnt unchanged.
- Buffer: 2-entry FIFO, order preserved. Pop when dout_valid&dout_ready. dout=head entry, 0 when empty. Simultaneous push+pop with count 1: count stays 1, dout becomes new word next cycle. Push into empty: dout_valid rises one cycle after parity strobe (latency 1 clk).
- locked=1 exactly while state is DATA or PAR, registered, updates the cycle after the causing strobe.
- dout_ready with dout_valid=0 has no effect. dout and dout_valid do not depend combinationally on dout_ready.

Test Plan:
- clear=1 for 2 cycles, then si=x, bit_en=1 -> dout=0, dout_valid=0, locked=0, par_err=0, overflow=0, frame_cnt=0.
- bit_en every cycle, dout_ready=1: bits 1,0,1,1 then 1,0,1,0,0,1,0,1 (0xA5) then parity 0 -> locked high after 4th bit; dout=8'hA5, dout_valid=1 for exactly 1 cycle starting 1 cycle after parity bit; frame_cnt=1.
- Same frame with parity 1 -> par_err one-cycle pulse, dout_valid stays 0, frame_cnt=0, locked=0; next correct frame 0x3C (parity 0) received normally.
- Hunt sliding: 1,1,0,1,1 then 0x00 then parity 0 -> no lock after 4th bit (window 1101), lock after 5th (1011); dout=8'h00 pushed.
- dout_ready=0, frames 0x01 (par 1), 0x02 (par 1), 0x03 (par 0) -> 0x01 and 0x02 buffered, 0x03 dropped, overflow=1, frame_cnt=2; then dout_ready=1 -> pops 0x01 then 0x02, dout_valid=0, overflow stays 1.
- bit_en one cycle in four, clear pulsed after 4 data bits of a frame -> locked=0 the cycle after clear, all outputs at reset values; following full frame 0xC3 (parity 0) yields dout=8'hC3, frame_cnt=1.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, assembles WIDTH data bits MSB-first,
// checks even parity and hands good words to a 2-entry valid/ready output buffer.
module sipo_frame_rx #(
   parameter int                  WIDTH    = 8,
   parameter int                  SYNC_LEN = 4,
   parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1011
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             si,
   input  logic             bit_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             locked,
   output logic             par_err,
   output logic             overflow,
   output logic [7:0]       frame_cnt
);

   localparam int FILL_W = $clog2(SYNC_LEN + 1);
   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_LEN);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_HUNT = 2'b00,
      ST_DATA = 2'b01,
      ST_PAR  = 2'b10
   } state_t;

   // Odd number of ones across data word plus parity bit means a corrupted frame.
   function automatic logic parity_odd(input logic [WIDTH-1:0] d, input logic p);
      return (^d) ^ p;
   endfunction

   state_t              state_r, state_s;
   logic [SYNC_LEN-1:0] window_r, window_s, win_shift_s;
   logic [FILL_W-1:0]   fill_r, fill_s;
   logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_s;
   logic [WIDTH-1:0]    data_r, data_s;
   logic                push_s, bad_par_s;

   logic [WIDTH-1:0]    mem_r [2];
   logic [WIDTH-1:0]    mem_s [2];
   logic                rd_ptr_r, rd_ptr_s, wr_ptr_s;
   logic [1:0]          cnt_r, cnt_s;
   logic                pop_s, push_ok_s, drop_s;
   logic [WIDTH-1:0]    head_s;

   logic [WIDTH-1:0]    dout_r;
   logic                dout_valid_r, locked_r, par_err_r, overflow_r;
   logic [7:0]          frame_cnt_r;

   // Frame FSM next-state: sync hunt, data assembly and parity decision.
   always_comb begin
      state_s     = state_r;
      window_s    = window_r;
      fill_s      = fill_r;
      bit_cnt_s   = bit_cnt_r;
      data_s      = data_r;
      push_s      = 1'b0;
      bad_par_s   = 1'b0;
      win_shift_s = (window_r << 1) | {{(SYNC_LEN-1){1'b0}}, si};
      if (bit_en) begin
         case (state_r)
            ST_HUNT: begin
               window_s = win_shift_s;
               if (fill_r != FILL_FULL) begin
                  fill_s = fill_r + FILL_ONE;
               end else begin
                  fill_s = fill_r;
               end
               if ((fill_s == FILL_FULL) && (win_shift_s == SYNC)) begin
                  state_s   = ST_DATA;
                  window_s  = {SYNC_LEN{1'b0}};
                  fill_s    = {FILL_W{1'b0}};
                  bit_cnt_s = {CNT_W{1'b0}};
               end else begin
                  state_s = ST_HUNT;
               end
            end
            ST_DATA: begin
               data_s    = {data_r[WIDTH-2:0], si};
               bit_cnt_s = bit_cnt_r + CNT_ONE;
               if (bit_cnt_r == LAST_BIT) begin
                  state_s = ST_PAR;
               end else begin
                  state_s = ST_DATA;
               end
            end
            ST_PAR: begin
               if (parity_odd(data_r, si)) begin
                  bad_par_s = 1'b1;
               end else begin
                  push_s = 1'b1;
               end
               // Re-entering the hunt starts from an empty window.
               state_s   = ST_HUNT;
               window_s  = {SYNC_LEN{1'b0}};
               fill_s    = {FILL_W{1'b0}};
               bit_cnt_s = {CNT_W{1'b0}};
            end
            default: begin
               state_s   = ST_HUNT;
               window_s  = {SYNC_LEN{1'b0}};
               fill_s    = {FILL_W{1'b0}};
               bit_cnt_s = {CNT_W{1'b0}};
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Output buffer next-state; a full buffer still accepts a push when the head leaves.
   always_comb begin
      pop_s     = dout_valid_r & dout_ready;
      push_ok_s = push_s & ((cnt_r != 2'd2) | pop_s);
      drop_s    = push_s & ~push_ok_s;
      wr_ptr_s  = rd_ptr_r ^ cnt_r[0];
      mem_s[0]  = mem_r[0];
      mem_s[1]  = mem_r[1];
      if (push_ok_s) begin
         mem_s[wr_ptr_s] = data_r;
      end else begin
         mem_s[wr_ptr_s] = mem_r[wr_ptr_s];
      end
      if (pop_s) begin
         rd_ptr_s = ~rd_ptr_r;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_s})
         2'b10:   cnt_s = cnt_r + 2'd1;
         2'b01:   cnt_s = cnt_r - 2'd1;
         default: cnt_s = cnt_r;
      endcase
      if (cnt_s == 2'd0) begin
         head_s = {WIDTH{1'b0}};
      end else begin
         head_s = mem_s[rd_ptr_s];
      end
   end

   // State, buffer and registered outputs with synchronous clear.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r      <= ST_HUNT;
         window_r     <= {SYNC_LEN{1'b0}};
         fill_r       <= {FILL_W{1'b0}};
         bit_cnt_r    <= {CNT_W{1'b0}};
         data_r       <= {WIDTH{1'b0}};
         mem_r[0]     <= {WIDTH{1'b0}};
         mem_r[1]     <= {WIDTH{1'b0}};
         rd_ptr_r     <= 1'b0;
         cnt_r        <= 2'd0;
         dout_r       <= {WIDTH{1'b0}};
         dout_valid_r <= 1'b0;
         locked_r     <= 1'b0;
         par_err_r    <= 1'b0;
         overflow_r   <= 1'b0;
         frame_cnt_r  <= 8'd0;
      end else begin
         state_r      <= state_s;
         window_r     <= window_s;
         fill_r       <= fill_s;
         bit_cnt_r    <= bit_cnt_s;
         data_r       <= data_s;
         mem_r[0]     <= mem_s[0];
         mem_r[1]     <= mem_s[1];
         rd_ptr_r     <= rd_ptr_s;
         cnt_r        <= cnt_s;
         dout_r       <= head_s;
         dout_valid_r <= (cnt_s != 2'd0);
         locked_r     <= (state_s == ST_DATA) || (state_s == ST_PAR);
         par_err_r    <= bad_par_s;
         overflow_r   <= overflow_r | drop_s;
         if (push_ok_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
   assign locked     = locked_r;
   assign par_err    = par_err_r;
   assign overflow   = overflow_r;
   assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: sync hunt, parity, buffer overflow and mid-frame clear.
module tb_sipo_frame_rx;

   logic       clk;
   logic       clear;
   logic       si;
   logic       bit_en;
   logic       dout_ready;
   logic [7:0] dout;
   logic       dout_valid;
   logic       locked;
   logic       par_err;
   logic       overflow;
   logic [7:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int gap    = 0;

   sipo_frame_rx #(.WIDTH(8), .SYNC_LEN(4), .SYNC(4'b1011)) dut (
      .clk        (clk),
      .clear      (clear),
      .si         (si),
      .bit_en     (bit_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .locked     (locked),
      .par_err    (par_err),
      .overflow   (overflow),
      .frame_cnt  (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // gap idle cycles precede each strobe so checks land right after the strobe edge
   task automatic send_bit(input logic b);
      for (int g = 0; g < gap; g++) begin
         bit_en = 1'b0;
         tick();
      end
      si     = b;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p);
      send_bits(16'h000B, 4);
      send_bits({8'h00, d}, 8);
      send_bit(p);
   endtask

   initial begin
      clear      = 1'b1;
      si         = 1'bx;
      bit_en     = 1'b1;
      dout_ready = 1'b0;
      tick();
      tick();
      chk("rst_dout", dout, 8'h00);
      chk("rst_valid", dout_valid, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_par_err", par_err, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_frame_cnt", frame_cnt, 8'd0);
      clear      = 1'b0;
      bit_en     = 1'b0;
      si         = 1'b0;
      dout_ready = 1'b1;
      tick();

      // good frame 0xA5, bit strobe every cycle
      send_bits(16'h0005, 3);
      chk("a5_locked_3", locked, 1'b0);
      send_bit(1'b1);
      chk("a5_locked_4", locked, 1'b1);
      send_bits(16'h00A5, 8);
      chk("a5_locked_data", locked, 1'b1);
      send_bit(1'b0);
      chk("a5_dout", dout, 8'hA5);
      chk("a5_valid", dout_valid, 1'b1);
      chk("a5_frame_cnt", frame_cnt, 8'd1);
      chk("a5_locked_end", locked, 1'b0);
      chk("a5_par_err", par_err, 1'b0);
      tick();
      chk("a5_valid_1cyc", dout_valid, 1'b0);
      chk("a5_dout_empty", dout, 8'h00);

      // bad parity then good 0x3C
      send_frame(8'hA5, 1'b1);
      chk("bad_par_err", par_err, 1'b1);
      chk("bad_valid", dout_valid, 1'b0);
      chk("bad_frame_cnt", frame_cnt, 8'd1);
      chk("bad_locked", locked, 1'b0);
      tick();
      chk("bad_par_pulse", par_err, 1'b0);
      send_frame(8'h3C, 1'b0);
      chk("3c_dout", dout, 8'h3C);
      chk("3c_valid", dout_valid, 1'b1);
      chk("3c_frame_cnt", frame_cnt, 8'd2);
      tick();
      chk("3c_valid_off", dout_valid, 1'b0);

      // sliding hunt: 1,1,0,1 no match, next 1 completes 1011
      send_bits(16'h000D, 4);
      chk("slide_nolock", locked, 1'b0);
      send_bit(1'b1);
      chk("slide_lock", locked, 1'b1);
      send_bits(16'h0000, 8);
      send_bit(1'b0);
      chk("slide_dout", dout, 8'h00);
      chk("slide_valid", dout_valid, 1'b1);
      chk("slide_frame_cnt", frame_cnt, 8'd3);
      tick();

      // buffer fills, third frame dropped
      dout_ready = 1'b0;
      send_frame(8'h01, 1'b1);
      chk("ov_dout1", dout, 8'h01);
      chk("ov_valid1", dout_valid, 1'b1);
      chk("ov_cnt1", frame_cnt, 8'd4);
      send_frame(8'h02, 1'b1);
      chk("ov_dout2", dout, 8'h01);
      chk("ov_cnt2", frame_cnt, 8'd5);
      chk("ov_flag2", overflow, 1'b0);
      send_frame(8'h03, 1'b0);
      chk("ov_flag3", overflow, 1'b1);
      chk("ov_cnt3", frame_cnt, 8'd5);
      chk("ov_dout3", dout, 8'h01);
      dout_ready = 1'b1;
      tick();
      chk("ov_pop1_dout", dout, 8'h02);
      chk("ov_pop1_valid", dout_valid, 1'b1);
      tick();
      chk("ov_pop2_valid", dout_valid, 1'b0);
      chk("ov_pop2_dout", dout, 8'h00);
      chk("ov_sticky", overflow, 1'b1);

      // strobe one cycle in four, clear mid-frame
      gap = 3;
      send_bits(16'h000B, 4);
      send_bits(16'h000C, 4);
      chk("clr_locked_before", locked, 1'b1);
      clear  = 1'b1;
      bit_en = 1'b1;
      si     = 1'b1;
      tick();
      clear  = 1'b0;
      bit_en = 1'b0;
      chk("clr_locked", locked, 1'b0);
      chk("clr_dout", dout, 8'h00);
      chk("clr_valid", dout_valid, 1'b0);
      chk("clr_par_err", par_err, 1'b0);
      chk("clr_overflow", overflow, 1'b0);
      chk("clr_frame_cnt", frame_cnt, 8'd0);
      send_frame(8'hC3, 1'b0);
      chk("c3_dout", dout, 8'hC3);
      chk("c3_valid", dout_valid, 1'b1);
      chk("c3_frame_cnt", frame_cnt, 8'd1);
      chk("c3_locked", locked, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
